// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam int OFFW  = 2;
   localparam int ADDRW = 32;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE
   } state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one 32-bit word per line, async read, sync write.
module dcache_array #(
   parameter int NSETS = 16,
   parameter int IDXW  = $clog2(NSETS),
   parameter int TAGW  = 30 - IDXW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [IDXW-1:0] widx,
   input  logic [TAGW-1:0] wtag,
   input  logic [31:0]     wdata,
   input  logic [IDXW-1:0] ridx,
   output logic            rvalid,
   output logic [TAGW-1:0] rtag,
   output logic [31:0]     rdata
);

   logic [NSETS-1:0] valid;
   logic [TAGW-1:0]  tags [NSETS];
   logic [31:0]      data [NSETS];

   always_ff @(posedge clk) begin
      if (reset)
         valid <= '0;
      else if (we)
         valid[widx] <= 1'b1;
   end

   // Tag/data carry no reset; a line is meaningless until its valid bit is set.
   always_ff @(posedge clk) begin
      if (we && !reset) begin
         tags[widx] <= wtag;
         data[widx] <= wdata;
      end
   end

   assign rvalid = valid[ridx];
   assign rtag   = tags[ridx];
   assign rdata  = data[ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller: FSM, hit logic and single-word memory handshake.
// Optional load hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NSETS = 16,
   parameter int IDXW  = $clog2(NSETS)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hitcount,
   output logic [31:0] misscount
`endif
);

   localparam int TAGW = ADDRW - OFFW - IDXW;

   state_t          state;
   logic [IDXW-1:0] idx;
   logic [TAGW-1:0] tag;
   logic            line_valid;
   logic [TAGW-1:0] line_tag;
   logic [31:0]     line_data;
   logic            hit;
   logic            ready;
   logic            arr_we;
   logic [31:0]     arr_wdata;
   logic            unused_bits;

   assign idx         = addrM[IDXW+OFFW-1:OFFW];
   assign tag         = addrM[ADDRW-1:IDXW+OFFW];
   assign unused_bits = ^addrM[OFFW-1:0];
   assign hit         = line_valid && (line_tag == tag);
   assign ready       = mem_req && mem_ready;

   // Fills always overwrite the line; stores only refresh a line they hit.
   assign arr_we    = ready && ((state == FILL) || (state == WRITE && hit));
   assign arr_wdata = (state == FILL) ? mem_rdata : writedataM;

   dcache_array #(.NSETS(NSETS), .IDXW(IDXW), .TAGW(TAGW)) u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (arr_we),
      .widx   (idx),
      .wtag   (tag),
      .wdata  (arr_wdata),
      .ridx   (idx),
      .rvalid (line_valid),
      .rtag   (line_tag),
      .rdata  (line_data)
   );

   always_comb begin
      stallM = 1'b0;
      case (state)
         IDLE:    stallM = memwriteM || (memreadM && !hit);
         FILL:    stallM = 1'b1;
         WRITE:   stallM = !ready;
         default: stallM = 1'b0;
      endcase
   end

   assign readdataM = (state == IDLE && memreadM && !memwriteM && hit) ? line_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memwriteM) begin
                  state     <= WRITE;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {addrM[ADDRW-1:OFFW], {OFFW{1'b0}}};
                  mem_wdata <= writedataM;
               end else if (memreadM && !hit) begin
                  state    <= FILL;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {addrM[ADDRW-1:OFFW], {OFFW{1'b0}}};
               end
            end
            FILL, WRITE: begin
               if (ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic from_fill;
   logic load_done;

   assign load_done = (state == IDLE) && memreadM && !memwriteM && hit;

   // A load that completes right after its own fill is a miss, not a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         from_fill <= 1'b0;
         hitcount  <= '0;
         misscount <= '0;
      end else begin
         from_fill <= (state == FILL) && ready;
         if (load_done) begin
            if (from_fill)
               misscount <= misscount + 32'd1;
            else
               hitcount <= hitcount + 32'd1;
         end
      end
   end
`endif

endmodule
